three_phase_sample_sequencer: RTL



---
 rtl/three_phase_sample_sequencer_pkg.sv | 25 ++
 rtl/sample_period_timer.sv | 34 +++
 rtl/three_phase_sample_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/three_phase_sample_sequencer_pkg.sv
// rtl/three_phase_sample_sequencer_pkg.sv - shared types and constants for the sample sequencer
package three_phase_sample_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVST  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_READ    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_COMMIT  = 3'd5
    } seq_state_e;

    typedef enum logic [2:0] {
        CH_VA = 3'd0,
        CH_VB = 3'd1,
        CH_VC = 3'd2,
        CH_IA = 3'd3,
        CH_IB = 3'd4,
        CH_IC = 3'd5
    } adc_ch_e;

    localparam logic [2:0] ADDR_OVR  = 3'd6;
    localparam logic [2:0] ADDR_STAT = 3'd7;

endpackage

// File: rtl/sample_period_timer.sv
// rtl/sample_period_timer.sv - free-running period counter producing one tick per sample period
module sample_period_timer #(
    parameter int SAMPLE_DIV = 5000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/three_phase_sample_sequencer.sv
// rtl/three_phase_sample_sequencer.sv - periodic six-channel ADC frame capture with coherent CPU bank
module three_phase_sample_sequencer
    import three_phase_sample_sequencer_pkg::*;
#(
    parameter int SAMPLE_DIV    = 5000,
    parameter int ADC_W         = 16,
    parameter int NUM_CH        = 6,
    parameter int MIN_BUSY_WAIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             adc_convst,
    input  logic             adc_busy,
    output logic             adc_rd,
    output logic [2:0]       adc_ch,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             sample_ack,
    output logic             new_sample,
    input  logic [2:0]       rd_addr,
    output logic [31:0]      rd_data
);

    localparam int WW = (MIN_BUSY_WAIT > 1) ? $clog2(MIN_BUSY_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MIN_BUSY_WAIT - 1);

    seq_state_e       state_q, state_d;
    logic [2:0]       ch_q, ch_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [ADC_W-1:0] shadow_q [NUM_CH];
    logic [ADC_W-1:0] bank_q   [NUM_CH];
    logic             new_sample_q;
    logic             tick_drop_q;
    logic [15:0]      overrun_q;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             tick;
    logic             commit;

    sample_period_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .enable_i  (enable),
        .tick_o    (tick)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        wcnt_d     = wcnt_q;
        adc_convst = 1'b0;
        adc_rd     = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_CONVST;
            end
            ST_CONVST: begin
                adc_convst = 1'b1;
                wcnt_d     = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // busy is not yet valid in the first cycles after CONVST
                if (wcnt_q < WAIT_LAST) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else if (!adc_busy) begin
                    ch_d    = CH_VA;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                adc_rd  = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (ch_q == 3'(NUM_CH - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            ADDR_OVR:  rd_data_d = {16'b0, overrun_q};
            ADDR_STAT: rd_data_d = {29'b0, tick_drop_q, (state_q != ST_IDLE), new_sample_q};
            default:   rd_data_d = {{(32 - ADC_W){bank_q[rd_addr][ADC_W-1]}}, bank_q[rd_addr]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            wcnt_q       <= '0;
            new_sample_q <= 1'b0;
            tick_drop_q  <= 1'b0;
            overrun_q    <= '0;
            rd_data_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                bank_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            wcnt_q    <= wcnt_d;
            rd_data_q <= rd_data_d;
            if (state_q == ST_CAPTURE) begin
                shadow_q[ch_q] <= adc_data;
            end
            if (tick && (state_q != ST_IDLE)) begin
                tick_drop_q <= 1'b1;
            end else if (sample_ack) begin
                tick_drop_q <= 1'b0;
            end
            // an unacknowledged frame is overwritten; newest data wins
            if (commit) begin
                new_sample_q <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    bank_q[i] <= shadow_q[i];
                end
                if (new_sample_q && !sample_ack && (overrun_q != 16'hFFFF)) begin
                    overrun_q <= overrun_q + 16'd1;
                end
            end else if (sample_ack) begin
                new_sample_q <= 1'b0;
            end
        end
    end

    assign adc_ch     = ch_q;
    assign new_sample = new_sample_q;
    assign rd_data    = rd_data_q;

endmodule
